// File: rtl/abnormal_solver.sv
// abnormal_solver: recovers the checker input that maps to a given target word,
// in = ((tgt ^ MASK) - ADDEND) mod 2^WIDTH, one DIGIT-bit slice per cycle, LSB first.
// Optional macro ABNORMAL_SOLVER_SELFCHECK_EN adds a forward re-check of every
// digit; without it self_check_err is tied low.
module abnormal_solver #(
    parameter int               WIDTH  = 256,
    parameter int               DIGIT  = 16,
    parameter int               NDIG   = 16,
    parameter logic [WIDTH-1:0] ADDEND = WIDTH'(1),
    parameter logic [WIDTH-1:0] MASK   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sol_data,
    output logic             busy,
    output logic             self_check_err
);

    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_x;
    logic [WIDTH-1:0]  r_sol;
    logic [CW-1:0]     r_cnt;
    logic              r_borrow;

    logic [DIGIT-1:0]  w_x_dig   [NDIG];
    logic [DIGIT-1:0]  w_add_dig [NDIG];
    logic [DIGIT-1:0]  w_x_cur;
    logic [DIGIT-1:0]  w_add_cur;
    logic [DIGIT:0]    w_d;
    logic              w_accept;

    // Split the latched word and the addend constant into per-digit slices
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_dig
            assign w_x_dig[gi]   = r_x[gi*DIGIT +: DIGIT];
            assign w_add_dig[gi] = ADDEND[gi*DIGIT +: DIGIT];
        end
    endgenerate

    assign w_x_cur   = w_x_dig[r_cnt];
    assign w_add_cur = w_add_dig[r_cnt];
    assign w_accept  = in_valid && (r_state == IDLE);

    // One digit of the ripple subtraction; the top bit is the borrow out
    assign w_d = {1'b0, w_x_cur} - {1'b0, w_add_cur} - {{DIGIT{1'b0}}, r_borrow};

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST_DIG) w_state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: latch the unmasked target, then write one result digit per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_sol    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_x      <= tgt_data ^ MASK;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
        end else if (r_state == RUN) begin
            r_sol[r_cnt*DIGIT +: DIGIT] <= w_d[DIGIT-1:0];
            r_borrow                    <= w_d[DIGIT];
            r_cnt                       <= r_cnt + 1'b1;
        end
    end

    assign sol_data = r_sol;

`ifdef ABNORMAL_SOLVER_SELFCHECK_EN
    logic [DIGIT-1:0] w_mask_dig [NDIG];
    logic [DIGIT-1:0] w_mask_cur;
    logic [DIGIT:0]   w_f;
    logic             r_carry;
    logic             r_err;

    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_mask
            assign w_mask_dig[gi] = MASK[gi*DIGIT +: DIGIT];
        end
    endgenerate

    assign w_mask_cur = w_mask_dig[r_cnt];
    // Forward digit rebuilt from the fresh result digit with its own carry chain
    assign w_f = {1'b0, w_d[DIGIT-1:0]} + {1'b0, w_add_cur} + {{DIGIT{1'b0}}, r_carry};

    // Sticky mismatch flag; the target digit is x ^ MASK of the latched word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == RUN) begin
            r_carry <= w_f[DIGIT];
            if ((w_f[DIGIT-1:0] ^ w_mask_cur) != (w_x_cur ^ w_mask_cur))
                r_err <= 1'b1;
        end
    end

    assign self_check_err = r_err && (r_state == DONE);
`else
    assign self_check_err = 1'b0;
`endif

endmodule

// File: tb/tb_abnormal_solver.sv
// Bench for abnormal_solver: three instances with different ADDEND/MASK constants
// driven in lockstep from shared inputs, checked against a whole-word model.
module tb_abnormal_solver;

    localparam int W = 256;
    localparam logic [W-1:0] ADD_C  = 256'h9e3779b97f4a7c15f39cc0605cedc8341082276bf3a27251f86c6a11d0c18e95;
    localparam logic [W-1:0] MASK_C = 256'hc2b2ae3d27d4eb4f165667b19e3779f9d6e8feb86659fd93a5a5a5a55a5a5a5a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] tgt_data = '0;
    logic [2:0]   ir, ov, bz, er;
    logic [W-1:0] sol [3];
    logic [W-1:0] add_k [3];
    logic [W-1:0] mask_k [3];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    abnormal_solver #(.ADDEND(256'h1), .MASK('0)) u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .tgt_data(tgt_data), .out_valid(ov[0]), .out_ready(out_ready),
        .sol_data(sol[0]), .busy(bz[0]), .self_check_err(er[0]));

    abnormal_solver #(.ADDEND('0), .MASK({W{1'b1}})) u_inv (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .tgt_data(tgt_data), .out_valid(ov[1]), .out_ready(out_ready),
        .sol_data(sol[1]), .busy(bz[1]), .self_check_err(er[1]));

    abnormal_solver #(.ADDEND(ADD_C), .MASK(MASK_C)) u_chk (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .tgt_data(tgt_data), .out_valid(ov[2]), .out_ready(out_ready),
        .sol_data(sol[2]), .busy(bz[2]), .self_check_err(er[2]));

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: invert ((in + a) ^ m) on the whole word
    function automatic logic [W-1:0] model(input logic [W-1:0] t, input logic [W-1:0] a,
                                          input logic [W-1:0] m);
        return (t ^ m) - a;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (ir[0] !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_idle", W'(ir), W'(3'b111));
    endtask

    // One full transaction; hold = number of DONE cycles with out_ready low
    task automatic run_txn(input int idx, input logic [W-1:0] t, input int hold);
        int n;
        logic [W-1:0] snap [3];
        wait_ready();
        in_valid = 1'b1;
        tgt_data = t;
        @(posedge clk); #1;
        tgt_data = rand256();
        chk("run_status", W'({bz, ir}), W'({3'b111, 3'b000}));
        // this pulse lands in RUN and must be ignored
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (ov[0] !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", W'(n + 1), W'(17));
        chk("out_valid_all", W'(ov), W'(3'b111));
        for (int k = 0; k < 3; k++) begin
            chk("sol", sol[k], model(t, add_k[k], mask_k[k]));
            chk("roundtrip", (sol[k] + add_k[k]) ^ mask_k[k], t);
            snap[k] = sol[k];
        end
        chk("self_check_err", W'(er), W'(3'b000));
        for (int h = 0; h < hold; h++) begin
            in_valid = $urandom_range(0, 1);
            tgt_data = rand256();
            @(posedge clk); #1;
            chk("hold_status", W'({ov, ir}), W'({3'b111, 3'b000}));
            for (int k = 0; k < 3; k++) chk("hold_sol", sol[k], snap[k]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("after_handshake", W'({ov, ir, bz}), W'({3'b000, 3'b111, 3'b000}));
        $display("txn %0d tgt=%h hold=%0d sol0=%h", idx, t, hold, sol[0]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] allones;
        int seen;
        allones   = {W{1'b1}};
        add_k[0]  = 256'h1;  mask_k[0] = '0;
        add_k[1]  = '0;      mask_k[1] = allones;
        add_k[2]  = ADD_C;   mask_k[2] = MASK_C;

        // Reset state while rst is held
        repeat (3) @(posedge clk);
        #1;
        chk("reset_status", W'({ir, ov, bz, er}), W'({3'b111, 3'b000, 3'b000, 3'b000}));
        chk("reset_sol", sol[0], '0);
        rst = 1'b0;

        // Directed corner cases
        run_txn(0, '0, 0);
        chk("t0_def_all_ones", sol[0], allones);
        run_txn(1, 256'h10000, 0);
        chk("t10000_def", sol[0], 256'hFFFF);
        run_txn(2, 256'h1234, 0);
        chk("t1234_inv", sol[1], ~(256'h1234));
        run_txn(3, rand256(), 5);

        // Reset in the middle of RUN
        wait_ready();
        in_valid = 1'b1;
        tgt_data = rand256();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_reset", W'({ov, ir, bz}), W'({3'b000, 3'b111, 3'b000}));
        chk("midrun_reset_sol", sol[0], '0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ov !== 3'b000) seen++;
        end
        chk("no_valid_after_reset", W'(seen), W'(0));
        run_txn(4, '0, 0);
        chk("post_reset_t0", sol[0], allones);

        // Randomized round trips
        for (int i = 0; i < 200; i++)
            run_txn(5 + i, rand256(), $urandom_range(0, 3));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
